// File: rtl/pearson_pkg.sv
// Shared types and the fixed 256-entry Pearson permutation for pearson_hash_stream.
package pearson_pkg;

    localparam int unsigned T_SIZE = 256;

    typedef enum logic [1:0] {
        FIRST = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] PEARSON_T [T_SIZE] = '{
         98,   6,  85, 150,  36,  23, 112, 164, 135, 207, 169,   5,  26,  64, 165, 219,
         61,  20,  68,  89, 130,  63,  52, 102,  24, 229, 132, 245,  80, 216, 195, 115,
         90, 168, 156, 203, 177, 120,   2, 190, 188,   7, 100, 185, 174, 243, 162,  10,
        237,  18, 253, 225,   8, 208, 172, 244, 255, 126, 101,  79, 145, 235, 228, 121,
        123, 251,  67, 250, 161,   0, 107,  97, 241, 111, 181,  82, 249,  33,  69,  55,
         59, 153,  29,   9, 213, 167,  84,  93,  30,  46,  94,  75, 151, 114,  73, 222,
        197,  96, 210,  45,  16, 227, 248, 202,  51, 152, 252, 125,  81, 206, 215, 186,
         39, 158, 178, 187, 131, 136,   1,  49,  50,  17, 141,  91,  47, 129,  60,  99,
        154,  35,  86, 171, 105,  34,  38, 200, 147,  58,  77, 118, 173, 246,  76, 254,
        133, 232, 196, 144, 198, 124,  53,   4, 108,  74, 223, 234, 134, 230, 157, 139,
        189, 205, 199, 128, 176,  19, 211, 236, 127, 192, 231,  70, 233,  88, 146,  44,
        183, 201,  22,  83,  13, 214, 116, 109, 159,  32,  95, 226, 140, 220,  57,  12,
        221,  31, 209, 182, 143,  92, 149, 184, 148,  62, 113,  65,  37,  27, 106, 166,
          3,  14, 204,  72,  21,  41,  56,  66,  28, 193,  40, 217,  25,  54, 179, 117,
        238,  87, 240, 155, 180, 170, 242, 212, 191, 163,  78, 218, 137, 194, 175, 110,
         43, 119, 224,  71, 122, 142,  42, 160, 104,  48, 247, 103,  15,  11, 138, 239
    };

    function automatic logic [7:0] pearson_lookup(input logic [7:0] idx);
        return PEARSON_T[idx];
    endfunction

endpackage

// File: rtl/pearson_lane.sv
// One 8-bit Pearson lane; lane index J offsets the first lookup so lanes diverge.
module pearson_lane
    import pearson_pkg::*;
#(
    parameter int unsigned J = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       first_i,
    input  logic       accum_i,
    input  logic [7:0] first_base_i,
    input  logic [7:0] data_i,
    output logic [7:0] h_o
);

    logic [7:0] h_q;
    logic [7:0] h_d;

    always_comb begin
        h_d = h_q;
        if (first_i) begin
            h_d = pearson_lookup(first_base_i + 8'(J));
        end else if (accum_i) begin
            h_d = pearson_lookup(h_q ^ data_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_q <= 8'd0;
        end else begin
            h_q <= h_d;
        end
    end

    assign h_o = h_q;

endmodule

// File: rtl/pearson_hash_stream.sv
// Byte-serial multi-lane Pearson hash with valid/ready framing and a held digest.
// Define PEARSON_HASH_SEED_EN to add a seed port mixed into the first lookup.
module pearson_hash_stream
    import pearson_pkg::*;
#(
    parameter int unsigned OUT_BYTES = 8,
    parameter int unsigned LEN_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*OUT_BYTES-1:0] out_hash,
`ifdef PEARSON_HASH_SEED_EN
    input  logic [7:0]             seed,
`endif
    output logic [LEN_W-1:0]       out_len
);

    state_t                 state_q;
    logic [LEN_W-1:0]       len_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [8*OUT_BYTES-1:0] hash_c;
    logic [7:0]             seed_c;
    logic [7:0]             first_base_c;
    logic                   beat_c;
    logic                   first_beat_c;
    logic                   accum_beat_c;

`ifdef PEARSON_HASH_SEED_EN
    assign seed_c = seed;
`else
    assign seed_c = 8'd0;
`endif

    assign beat_c       = in_valid && in_ready_q;
    assign first_beat_c = beat_c && (state_q == FIRST);
    assign accum_beat_c = beat_c && (state_q == ACCUM);
    assign first_base_c = in_data + seed_c;

    for (genvar j = 0; j < OUT_BYTES; j++) begin : g_lane
        pearson_lane #(.J(j)) u_lane (
            .clk          (clk),
            .rst          (rst),
            .first_i      (first_beat_c),
            .accum_i      (accum_beat_c),
            .first_base_i (first_base_c),
            .data_i       (in_data),
            .h_o          (hash_c[8*j +: 8])
        );
    end

    // Frame FSM; in_ready/out_valid are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FIRST;
            len_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FIRST: begin
                    if (beat_c) begin
                        len_q <= LEN_W'(1);
                        if (in_last) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (beat_c) begin
                        if (len_q != '1) begin
                            len_q <= len_q + LEN_W'(1);
                        end
                        if (in_last) begin
                            state_q     <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= FIRST;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= FIRST;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Lane and length registers keep stale values after a handshake, so mask them.
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_hash  = out_valid_q ? hash_c : '0;
    assign out_len   = out_valid_q ? len_q : '0;

endmodule

// File: tb/tb_pearson_hash_stream.sv
// Self-checking bench for pearson_hash_stream: vector table, corner sequences, random scoreboard.
module tb_pearson_hash_stream;

    localparam int unsigned OB      = 8;
    localparam int unsigned LW      = 8;
    localparam int unsigned TIMEOUT = 2000;

    localparam logic [7:0] TB_T [256] = '{
         98,   6,  85, 150,  36,  23, 112, 164, 135, 207, 169,   5,  26,  64, 165, 219,
         61,  20,  68,  89, 130,  63,  52, 102,  24, 229, 132, 245,  80, 216, 195, 115,
         90, 168, 156, 203, 177, 120,   2, 190, 188,   7, 100, 185, 174, 243, 162,  10,
        237,  18, 253, 225,   8, 208, 172, 244, 255, 126, 101,  79, 145, 235, 228, 121,
        123, 251,  67, 250, 161,   0, 107,  97, 241, 111, 181,  82, 249,  33,  69,  55,
         59, 153,  29,   9, 213, 167,  84,  93,  30,  46,  94,  75, 151, 114,  73, 222,
        197,  96, 210,  45,  16, 227, 248, 202,  51, 152, 252, 125,  81, 206, 215, 186,
         39, 158, 178, 187, 131, 136,   1,  49,  50,  17, 141,  91,  47, 129,  60,  99,
        154,  35,  86, 171, 105,  34,  38, 200, 147,  58,  77, 118, 173, 246,  76, 254,
        133, 232, 196, 144, 198, 124,  53,   4, 108,  74, 223, 234, 134, 230, 157, 139,
        189, 205, 199, 128, 176,  19, 211, 236, 127, 192, 231,  70, 233,  88, 146,  44,
        183, 201,  22,  83,  13, 214, 116, 109, 159,  32,  95, 226, 140, 220,  57,  12,
        221,  31, 209, 182, 143,  92, 149, 184, 148,  62, 113,  65,  37,  27, 106, 166,
          3,  14, 204,  72,  21,  41,  56,  66,  28, 193,  40, 217,  25,  54, 179, 117,
        238,  87, 240, 155, 180, 170, 242, 212, 191, 163,  78, 218, 137, 194, 175, 110,
         43, 119, 224,  71, 122, 142,  42, 160, 104,  48, 247, 103,  15,  11, 138, 239
    };

    typedef struct packed {
        logic [63:0] hash;
        logic [7:0]  len;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [63:0] hash;
        logic [7:0]  len;
    } vec_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic [7:0]  in_data   = 8'd0;
    logic        in_last   = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [63:0] out_hash;
    logic [7:0]  out_len;

    int   checks     = 0;
    int   passes     = 0;
    int   ready_mode = 1;
    exp_t sb[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    pearson_hash_stream #(.OUT_BYTES(OB), .LEN_W(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hash  (out_hash),
`ifdef PEARSON_HASH_SEED_EN
        .seed      (8'd0),
`endif
        .out_len   (out_len)
    );

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passes++;
        end
    endfunction

    function automatic exp_t model(input logic [7:0] msg[$]);
        exp_t       e;
        logic [7:0] h;
        e.hash = '0;
        for (int j = 0; j < OB; j++) begin
            h = TB_T[8'(msg[0] + 8'(j))];
            for (int i = 1; i < msg.size(); i++) h = TB_T[h ^ msg[i]];
            e.hash[8*j +: 8] = h;
        end
        e.len = (msg.size() > 255) ? 8'hFF : 8'(msg.size());
        return e;
    endfunction

    // out_ready: 0 = hold low, 1 = hold high, else random.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Scoreboard monitor: compare every digest handshake, idle outputs must read zero.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_digest", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("digest_hash", out_hash, e.hash);
                    check("digest_len", 64'(out_len), 64'(e.len));
                end
            end else if (!out_valid) begin
                check("idle_hash_zero", out_hash, 64'd0);
                check("idle_len_zero", 64'(out_len), 64'd0);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the beat.
    task automatic drive_byte(input logic [7:0] d, input logic last, input bit strict);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        if (strict) check("stream_in_ready", 64'(in_ready), 64'd1);
        while (!in_ready && waited < TIMEOUT) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) check("beat_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < TIMEOUT) begin
            waited++;
            @(negedge clk);
        end
        if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] msg[$];
        exp_t       e;
        int         n;
        int         waited;

        vecs[0] = '{n: 1, b0: 8'h00, b1: 8'h00, hash: 64'hA470_1724_9655_0662, len: 8'd1};
        vecs[1] = '{n: 1, b0: 8'hFF, b1: 8'h00, hash: 64'h7017_2496_5506_62EF, len: 8'd1};
        vecs[2] = '{n: 2, b0: 8'h00, b1: 8'h00, hash: 64'hB027_66B1_35A7_70D2, len: 8'd2};
        vecs[3] = '{n: 1, b0: 8'h01, b1: 8'h00, hash: 64'h87A4_7017_2496_5506, len: 8'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_hash", out_hash, 64'd0);
        check("rst_out_len", 64'(out_len), 64'd0);
        @(posedge clk);
        #1;

        // Vector table: known digests, latency and handshake turnaround.
        for (int v = 0; v < 4; v++) begin
            sb.push_back('{hash: vecs[v].hash, len: vecs[v].len});
            if (vecs[v].n == 2) begin
                drive_byte(vecs[v].b0, 1'b0, 1'b1);
                drive_byte(vecs[v].b1, 1'b1, 1'b1);
            end else begin
                drive_byte(vecs[v].b0, 1'b1, 1'b1);
            end
            @(negedge clk);
            check("latency_valid", 64'(out_valid), 64'd1);
            check("done_in_ready", 64'(in_ready), 64'd0);
            @(posedge clk);
            #1;
            @(negedge clk);
            check("ready_after_hs", 64'(in_ready), 64'd1);
            check("valid_after_hs", 64'(out_valid), 64'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: digest held stable, in_valid pulses ignored.
        @(negedge clk);
        ready_mode = 0;
        @(posedge clk);
        #1;
        sb.push_back('{hash: 64'h87A4_7017_2496_5506, len: 8'd1});
        drive_byte(8'h01, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_hash", out_hash, 64'h87A4_7017_2496_5506);
            check("bp_len", 64'(out_len), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            in_valid = (k % 2 == 0);
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
        @(negedge clk);
        in_valid   = 1'b0;
        ready_mode = 1;
        waited     = 0;
        while (out_valid && waited < 10) begin
            waited++;
            @(negedge clk);
        end
        check("bp_released", 64'(out_valid), 64'd0);
        check("bp_ready_back", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        sb.push_back('{hash: 64'h7017_2496_5506_62EF, len: 8'd1});
        drive_byte(8'hFF, 1'b1, 1'b1);
        wait_drain();

        // Reset mid-message aborts it; next message starts clean.
        drive_byte(8'h12, 1'b0, 1'b1);
        drive_byte(8'h34, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back('{hash: 64'hA470_1724_9655_0662, len: 8'd1});
        drive_byte(8'h00, 1'b1, 1'b1);
        wait_drain();

        // Random messages with input gaps and random out_ready.
        ready_mode = 2;
        for (int m = 0; m < 40; m++) begin
            n = (m == 0) ? 300 : int'($urandom_range(1, 300));
            msg.delete();
            for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
            e = model(msg);
            sb.push_back(e);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    in_last  = 1'($urandom);
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                drive_byte(msg[i], (i == n - 1), 1'b0);
            end
        end
        wait_drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pearson_hash_stream.md
Name: pearson_hash_stream

Overview:
- Byte-serial, multi-lane Pearson hash engine that generates a wide digest.
- Consumes a framed byte stream over a valid/ready handshake, one byte per cycle.
- Runs OUT_BYTES independent 8-bit Pearson lanes in parallel. Lane j seeds its first lookup with (first byte + j) mod 256.
- Message length is variable (set by in_last). Emits digest plus byte count to the downstream integrity/lookup logic.

Parameters:
- OUT_BYTES, 8, number of parallel hash lanes; digest width is 8*OUT_BYTES; legal range 1..32.
- LEN_W, 16, width of the message byte counter.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  input byte valid
- in_ready  output  1  engine can accept a byte
- in_data  input  8  message byte
- in_last  input  1  marks final byte of message
- out_valid  output  1  digest valid
- out_ready  input  1  downstream accepts digest
- out_hash  output  8*OUT_BYTES  digest; lane 0 in bits [7:0], lane j in [8j+7:8j]
- out_len  output  LEN_W  bytes in the hashed message, saturating

Behaviour:
- T is the fixed 256-entry byte permutation held in the package. Index 0 maps to 98, index 1 to 6, and index 255 to 239.
- Beat: in_valid && in_ready at a rising clk edge.
- FSM states: FIRST (expecting byte 0), ACCUM (expecting byte ≥1), DONE (holding digest).
- in_ready is 1 in FIRST and ACCUM, and 0 in DONE. It is a registered state decode with no combinational path from out_ready.
- FIRST beat:
  - Lane j register h_j <= T[(in_data + j) mod 256], with 8-bit wrap.
  - len <= 1.
  - in_last=1 → DONE; otherwise → ACCUM.
- ACCUM beat:
  - h_j <= T[h_j ^ in_data].
  - len <= len+1, saturating at all-ones.
  - in_last=1 → DONE.
- No beat: state and lane registers hold.
- DONE:
  - out_valid=1; out_hash = concatenated h_j; out_len = len.
  - All three are stable until out_ready=1. The handshake cycle returns to FIRST.
  - In DONE, in_valid is ignored with no side effects.
- Latency: digest is valid the cycle after the last beat.
- Throughput: one byte per cycle while streaming, plus 1 idle cycle per message for the digest handshake (earliest in_ready is the cycle after out handshake).
- A single-byte message (in_last on the first beat) is legal. Zero-length messages are impossible by construction.
- Reset values: state=FIRST, all h_j=0, len=0, out_valid=0, in_ready=1 from the first cycle after release. out_hash=0 and out_len=0 while not valid.
- Reset asserted mid-message or in DONE aborts the message immediately; the pending digest is lost.
- in_data and in_last are don't-care when in_valid=0.

Optional Feature:
- Macro: PEARSON_HASH_SEED_EN.
- With the macro:
  - Adds input port seed [7:0].
  - seed is sampled on the FIRST beat only.
  - The first lookup becomes T[(in_data + j + seed) mod 256]; subsequent beats are unchanged.
- Without the macro: no port; behaviour is identical to seed=0.

Decomposition:
- Package pearson_pkg contains:
  - localparam PEARSON_T (256×8 permutation constant)
  - function pearson_lookup(byte idx) returning T[idx]
  - typedef state_t {FIRST, ACCUM, DONE}
- Sub-module pearson_lane, instantiated OUT_BYTES times via generate. Each instance contains:
  - one 8-bit h register
  - first/accumulate lookup mux
  - lane index j supplied as a parameter
- The top level owns the FSM, length counter, and handshake.

Test Plan:
- Single byte 0x00 with in_last, out_ready=1 → one cycle later out_valid=1, out_hash=64'hA470_1724_9655_0662, out_len=1.
- Single byte 0xFF (lane wrap) → lane0=0xEF (T[255]), lane1=0x62 (T[0]), out_len=1.
- Two bytes 0x00, 0x00 back-to-back → lane0=0xD2 (T[98]=210), out_len=2; in_ready stays 1 across both beats.
- Backpressure: hold out_ready=0 for 5 cycles after digest →
  - out_valid, out_hash, out_len stable; in_ready=0.
  - in_valid pulses meanwhile do not change the result.
  - Release: handshake, then FIRST, and the next message hashes correctly.
- Reset mid-message: send 0x12, 0x34 (no last), pulse rst → out_valid=0, state FIRST. Then single 0x00 with last yields 64'hA470_1724_9655_0662.
- Random messages of length 1..300 with random in_valid/out_ready gaps, checked against a software Pearson model. This also covers saturation with LEN_W=8 and a 300-byte message (out_len=8'hFF).
